// File: rtl/control_mux_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | control_mux_stream: per-lane mux_reset strobe generator for stream muxes |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module control_mux_stream #(
   parameter int NUM_CH  = 4,
   parameter int PERIOD  = 8,
   parameter int ACT_LEN = 4,
   parameter int STAGGER = 1,
   parameter int RND_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [RND_W-1:0]  n_rounds,
   input  logic              stall,
   input  logic              abort,
   output logic [NUM_CH-1:0] mux_reset,
   output logic              busy,
   output logic              done
);

   localparam int TAIL  = (NUM_CH - 1) * STAGGER;
   localparam int T_MAX = ((2 ** RND_W) - 1) * PERIOD + TAIL;
   localparam int T_W   = $clog2(T_MAX + 1);
   localparam int PH_W  = $clog2(PERIOD);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [T_W-1:0]    t_q, t_d;
   logic [PH_W-1:0]   ph_q, ph_d;
   logic [T_W-1:0]    limit_q, limit_d;
   logic [NUM_CH-1:0] mux_reset_q, mux_reset_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [T_W-1:0]    last_tick;
   logic [NUM_CH-1:0] lane_hold;

   assign last_tick = limit_q + T_W'(TAIL) - T_W'(1);

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      ph_d    = ph_q;
      limit_d = limit_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!abort && start) begin
               limit_d = T_W'(n_rounds) * T_W'(PERIOD);
               t_d     = '0;
               ph_d    = '0;
               // Zero rounds completes immediately without ever releasing a lane.
               if (n_rounds == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  busy_d  = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (!stall) begin
               if (t_q == last_tick) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  t_d  = t_q + T_W'(1);
                  ph_d = (ph_q == PH_W'(PERIOD - 1)) ? '0 : ph_q + PH_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Lane phase is derived from the shared phase counter minus a constant offset,
   // so no per-lane divider is needed.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      localparam int DLY = i * STAGGER;
      localparam int OFF = DLY % PERIOD;

      logic [PH_W:0] ph_ext;
      logic [PH_W:0] lane_ph;
      logic          started;
      logic          in_range;

      assign ph_ext = {1'b0, ph_d};

      if (OFF == 0) begin : g_no_off
         assign lane_ph = ph_ext;
      end else begin : g_off
         assign lane_ph = (ph_ext >= (PH_W+1)'(OFF)) ? (ph_ext - (PH_W+1)'(OFF))
                                                     : (ph_ext + (PH_W+1)'(PERIOD - OFF));
      end

      if (DLY == 0) begin : g_first
         assign started = 1'b1;
      end else begin : g_later
         assign started = (t_d >= T_W'(DLY));
      end

      assign in_range     = started && (t_d < (limit_d + T_W'(DLY)));
      assign lane_hold[i] = !(in_range && (lane_ph < (PH_W+1)'(ACT_LEN)));
   end

   // In RUN the registered strobes always equal the lane law of the held tick.
   assign mux_reset_d = (state_d == ST_RUN) ? lane_hold : '1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         t_q         <= '0;
         ph_q        <= '0;
         limit_q     <= '0;
         mux_reset_q <= '1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         ph_q        <= ph_d;
         limit_q     <= limit_d;
         mux_reset_q <= mux_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign mux_reset = mux_reset_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_control_mux_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_control_mux_stream: directed self-checking bench for control_mux_stream|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_control_mux_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, stall, abort;
   logic [7:0] n_rounds;
   logic [3:0] mux_reset;
   logic       busy, done;

   logic       start8, stall8, abort8;
   logic [7:0] n_rounds8;
   logic [7:0] mux8;
   logic       busy8, done8;

   int tests = 0;
   int fails = 0;

   logic [3:0] exp_r2 [0:21];
   logic [3:0] exp_st [0:16];

   always #5 clk = ~clk;

   control_mux_stream dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .n_rounds  (n_rounds),
      .stall     (stall),
      .abort     (abort),
      .mux_reset (mux_reset),
      .busy      (busy),
      .done      (done)
   );

   control_mux_stream #(
      .NUM_CH  (8),
      .PERIOD  (4),
      .ACT_LEN (1),
      .STAGGER (0),
      .RND_W   (8)
   ) dut8 (
      .clk       (clk),
      .rst       (rst),
      .start     (start8),
      .n_rounds  (n_rounds8),
      .stall     (stall8),
      .abort     (abort8),
      .mux_reset (mux8),
      .busy      (busy8),
      .done      (done8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [3:0] m, input logic b, input logic d);
      chk({tag, "_mux"},  {28'd0, mux_reset}, {28'd0, m});
      chk({tag, "_busy"}, {31'd0, busy},      {31'd0, b});
      chk({tag, "_done"}, {31'd0, done},      {31'd0, d});
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      exp_r2 = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC,
                 4'h8, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
      exp_st = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1, 4'h3, 4'h7,
                 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

      rst = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0; n_rounds = 8'd0;
      start8 = 1'b0; stall8 = 1'b0; abort8 = 1'b0; n_rounds8 = 8'd0;
      #1 rst = 1'b1;
      #2 chk3("reset_async", 4'hF, 1'b0, 1'b0);
      cyc();
      chk3("reset_held", 4'hF, 1'b0, 1'b0);
      chk("reset_dut8_mux", {24'd0, mux8}, 32'hFF);
      rst = 1'b0;

      // R=2 run, with start re-asserted mid-run that must be ignored
      n_rounds = 8'd2; start = 1'b1;
      for (int c = 1; c <= 21; c++) begin
         cyc();
         chk3($sformatf("r2_c%0d", c), exp_r2[c], (c <= 19), (c == 20));
         start    = (c == 5) || (c == 6);
         n_rounds = (c == 5) ? 8'd7 : 8'd2;
      end
      start = 1'b0;

      // R=1 with a three-cycle stall starting at cycle 3
      n_rounds = 8'd1; start = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         cyc();
         chk3($sformatf("stall_c%0d", c), exp_st[c], (c <= 14), (c == 15));
         start = 1'b0;
         stall = (c >= 3) && (c <= 5);
      end
      stall = 1'b0;

      // Abort mid-run, restart, abort again, then start+abort together in IDLE
      n_rounds = 8'd2; start = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         logic [3:0] em;
         logic       eb;
         cyc();
         if (c <= 5)       begin em = exp_r2[c]; eb = 1'b1; end
         else if (c == 8)  begin em = 4'hE;      eb = 1'b1; end
         else if (c == 9)  begin em = 4'hC;      eb = 1'b1; end
         else              begin em = 4'hF;      eb = 1'b0; end
         chk3($sformatf("abort_c%0d", c), em, eb, 1'b0);
         start = (c == 7) || (c == 10);
         abort = (c == 5) || (c == 9) || (c == 10);
      end
      start = 1'b0; abort = 1'b0;

      // Zero rounds: immediate done, no lane released
      n_rounds = 8'd0; start = 1'b1;
      cyc();
      chk3("r0_c1", 4'hF, 1'b0, 1'b1);
      start = 1'b0;
      cyc();
      chk3("r0_c2", 4'hF, 1'b0, 1'b0);

      // Eight lanes, no stagger, single-cycle window, R=3
      n_rounds8 = 8'd3; start8 = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         cyc();
         chk($sformatf("w8_mux_c%0d", c), {24'd0, mux8},
             ((c == 1) || (c == 5) || (c == 9)) ? 32'h00 : 32'hFF);
         chk($sformatf("w8_busy_c%0d", c), {31'd0, busy8}, {31'd0, (c <= 12)});
         chk($sformatf("w8_done_c%0d", c), {31'd0, done8}, {31'd0, (c == 13)});
         start8 = 1'b0;
      end

      // Asynchronous reset between clock edges mid-run
      n_rounds = 8'd2; start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         cyc();
         chk3($sformatf("arst_c%0d", c), exp_r2[c], 1'b1, 1'b0);
         start = 1'b0;
      end
      #1 rst = 1'b1;
      #1 chk3("arst_mid", 4'hF, 1'b0, 1'b0);
      rst = 1'b0;
      cyc();
      chk3("arst_after", 4'hF, 1'b0, 1'b0);
      n_rounds = 8'd1; start = 1'b1;
      cyc();
      chk3("arst_restart", 4'hE, 1'b1, 1'b0);
      start = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/control_mux_stream.md
# control_mux_stream

Parametrised controller that drives the per-lane `mux_reset` strobes for the input-streaming muxes of the matrix-multiply datapath. It is the generalised form of the fixed 4-lane rotating strobe generator. Lane count, window length, period and inter-lane stagger are all parameters. It adds a start/busy/done handshake, a programmable round count, stall and abort. It sits between the layer sequencer, which issues `start`, and the bank of stream muxes.

## Interface

- `NUM_CH`, 4: number of mux lanes (≥1).
- `PERIOD`, 8: cycles per lane window period (≥2).
- `ACT_LEN`, 4: cycles per period a lane is released (1..PERIOD).
- `STAGGER`, 1: per-lane delay in cycles, lane i lags lane 0 by i·STAGGER (≥0).
- `RND_W`, 8: width of round-count input.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `n_rounds`  in  RND_W  number of periods per lane; sampled with `start`.
- `stall`  in  1  freeze run (tick, outputs, state hold).
- `abort`  in  1  terminate run immediately.
- `mux_reset`  out  NUM_CH  per-lane hold strobe: 1 = lane held, 0 = lane streaming.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at normal run completion.

## Operation

- States:
  - IDLE: `mux_reset` all ones, `busy`=0.
  - RUN: active run.
  - DONE: one cycle, `done`=1, `mux_reset` all ones, `busy`=0; next state IDLE.
- IDLE→RUN on `start`=1. Latch `n_rounds` as R and clear tick t to 0.
- RUN: t increments by 1 each cycle with `stall`=0. Last tick L = R·PERIOD + (NUM_CH−1)·STAGGER − 1. On the cycle showing t=L with no stall, next state is DONE.
- Lane law: q_i = t − i·STAGGER. `mux_reset[i]`=0 iff 0 ≤ q_i < R·PERIOD and (q_i mod PERIOD) < ACT_LEN; otherwise 1.
- Implementation may use per-lane phase/round counters instead of t. Output must match the lane law exactly.
- R=0: IDLE→RUN is skipped. `start` goes straight to DONE (done pulse next cycle), and no lane is ever released.
- `stall` in RUN: t, state and `mux_reset` hold their values. `stall` is ignored in IDLE and DONE.
- `abort`=1 in RUN or DONE: next state IDLE, `mux_reset` all ones, no `done` pulse. `abort` has priority over `stall` and completion.
- `start` while in RUN or DONE is ignored. No queuing.
- `start` and `abort` together in IDLE: `abort` wins and the block stays IDLE.
- Counter widths are sized from parameters so that L never overflows. There is no wrap of t within a run.

## Timing

- All outputs are registered.
- Reset value: state IDLE, `mux_reset` = all ones, `busy`=0, `done`=0, t=0.
- `rst` asserted mid-run: outputs take their reset values asynchronously. No `done`.
- Latency: `start` sampled at edge k, so the cycle after edge k shows t=0 with `busy`=1 and the lane-law outputs for t=0.
- `busy` is high for exactly L+1 unstalled RUN cycles plus any stall cycles.
- `done` is high in the cycle immediately after the t=L cycle. `busy` is 0 in that cycle.
- Earliest next `start` is accepted in the DONE cycle's successor (IDLE), one cycle after `done`.
- `abort` sampled at edge k gives outputs all ones and `busy`=0 from the cycle after edge k.

## Test plan

- Defaults, R=2, `start` at cycle 0:
  - Cycles 1–4: `mux_reset` = 1110, 1100, 1000, 0000.
  - Cycles 5–8: 0001, 0011, 0111, 1111.
  - Cycle 9: 1110.
  - L=18, so `busy` is high cycles 1–19, `done` pulses at cycle 20, and `mux_reset` is 1111 at cycles 16–20.
- Defaults, R=1, `stall` high for 3 cycles starting at cycle 3: `mux_reset` holds 1000 for cycles 3–6, resumes 0000 at cycle 7, and `done` pulses at cycle 15 instead of 12.
- `abort` at cycle 5 of an R=2 run: `mux_reset`=1111 and `busy`=0 from cycle 6, with no `done`. A `start` at cycle 7 restarts cleanly with 1110 at cycle 8.
- R=0 `start`: `done` pulses in the next cycle, `busy` never rises, and `mux_reset` stays 1111.
- NUM_CH=8, PERIOD=4, ACT_LEN=1, STAGGER=0, R=3:
  - All lanes release together: `mux_reset` is 0x00 at ticks 0, 4 and 8, and 0xFF at every other tick.
  - L=11 and `done` comes 13 cycles after `start`.
- Async `rst` pulse mid-run between clock edges: outputs go to 1111/0/0 without waiting for `clk`. `start` repeated during RUN is ignored (done timing unchanged).
